// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl: 4-digit multiplexed 7-segment scanner with hex/spin modes and a frame-synchronous load handshake
module seven_segment_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int SPIN_DIV  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [1:0]  mode,
  input  logic        load,
  output logic        ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int SW = $clog2(TICK_DIV);
  localparam int CW = $clog2(SPIN_DIV + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CYC);
  localparam logic [CW-1:0] SPIN_LAST  = CW'(SPIN_DIV - 1);
  localparam logic [111:0] HEX_LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [SW-1:0] slot;
  logic [1:0]    digit;
  logic [CW-1:0] spin_cnt;
  logic [2:0]    pos;
  logic [15:0]   act_val, pend_val;
  logic [1:0]    act_mode, pend_mode, mode_n;
  logic          pend, boundary, blank, enter_spin;
  logic [3:0]    nib;
  assign boundary   = slot == SLOT_LAST && digit == 2'd3;
  assign mode_n     = mode == 2'b11 ? 2'b00 : mode;
  assign enter_spin = boundary && pend && pend_mode == 2'b10 && act_mode != 2'b10;
  // Free-running scan counters, pending/active load registers and spin animation state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot      <= '0;
      digit     <= '0;
      spin_cnt  <= '0;
      pos       <= '0;
      act_val   <= '0;
      act_mode  <= '0;
      pend_val  <= '0;
      pend_mode <= '0;
      pend      <= 1'b0;
    end else begin
      slot <= slot == SLOT_LAST ? '0 : slot + 1'b1;
      if (slot == SLOT_LAST) digit <= digit + 1'b1;
      if (boundary && pend) begin
        act_val  <= pend_val;
        act_mode <= pend_mode;
        pend     <= 1'b0;
      end else if (load && !pend) begin
        pend      <= 1'b1;
        pend_val  <= value;
        pend_mode <= mode_n;
      end
      if (enter_spin) begin
        spin_cnt <= '0;
        pos      <= '0;
      end else if (boundary) begin
        spin_cnt <= spin_cnt == SPIN_LAST ? '0 : spin_cnt + 1'b1;
        if (spin_cnt == SPIN_LAST) pos <= pos == 3'd5 ? 3'd0 : pos + 3'd1;
      end
    end
  end
  // Output decode from registered state only
  always_comb begin
    nib        = act_val[{digit, 2'b00} +: 4];
    blank      = slot < SLOT_BLANK || !(act_mode == 2'b01 || act_mode == 2'b10);
    seg        = blank ? 7'd0 : act_mode == 2'b10 ? 7'd1 << pos : HEX_LUT[7 * int'(nib) +: 7];
    an         = blank ? 4'd0 : 4'd1 << digit;
    ready      = !pend;
    frame_done = boundary;
  end
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb_seven_segment_scan_ctrl: directed+random bench against a frame-level reference model
module tb_seven_segment_scan_ctrl;
  localparam int TD = 4, BC = 1, SD = 2;
  logic        clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [15:0] value = '0;
  logic [1:0]  mode = '0;
  logic        ready, frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;
  int checks = 0, errors = 0;
  int t, a_mode, p_mode, base;
  logic [15:0] a_val, p_val;
  bit pend;
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_segment_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC), .SPIN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .value(value), .mode(mode), .load(load),
    .ready(ready), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; a_mode = 0; p_mode = 0; base = 0; a_val = '0; p_val = '0; pend = 0;
  endtask

  task automatic tick(input bit ld, input logic [15:0] v, input logic [1:0] m);
    int slot, dig, f, pp, nm;
    bit bl, fd;
    logic [6:0] es;
    logic [3:0] ea;
    @(negedge clk);
    slot = t % TD;
    dig  = (t / TD) % 4;
    f    = t / (TD * 4);
    fd   = slot == TD - 1 && dig == 3;
    bl   = slot < BC || !(a_mode == 1 || a_mode == 2);
    pp   = ((f - base) / SD) % 6;
    es   = bl ? 7'd0 : a_mode == 2 ? 7'(1 << pp) : hex_tab[int'((a_val >> (4 * dig)) & 16'hF)];
    ea   = bl ? 4'd0 : 4'(1 << dig);
    chk("seg", seg, es);
    chk("an", 7'(an), 7'(ea));
    chk("frame_done", 7'(frame_done), 7'(fd));
    chk("ready", 7'(ready), 7'(!pend));
    load = ld; value = v; mode = m;
    if (fd && pend) begin
      nm = p_mode;
      if (nm == 2 && a_mode != 2) base = f + 1;
      a_mode = nm; a_val = p_val; pend = 0;
    end else if (ld && !pend) begin
      pend = 1; p_val = v; p_mode = m == 2'd3 ? 0 : int'(m);
    end
    @(posedge clk);
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 16'($urandom), 2'($urandom));
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b0;
    load = 1'b0;
    #1;
    chk("rst_seg", seg, 7'd0);
    chk("rst_an", 7'(an), 7'd0);
    chk("rst_fd", 7'(frame_done), 7'd0);
    chk("rst_ready", 7'(ready), 7'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    rst_pulse();
    idle(32);
    tick(1'b1, 16'h1234, 2'b01);
    idle(2);
    tick(1'b1, 16'hFFFF, 2'b01);
    idle(40);
    while (t % 16 != 15) idle(1);
    tick(1'b1, 16'($urandom), 2'b01);
    idle(40);
    tick(1'b1, 16'($urandom), 2'b10);
    idle(16 * 15);
    tick(1'b1, 16'($urandom), 2'b10);
    idle(16 * 4);
    tick(1'b1, 16'($urandom), 2'b11);
    idle(36);
    repeat (30) begin
      tick(1'($urandom), 16'($urandom), 2'($urandom));
      idle($urandom_range(0, 20));
    end
    tick(1'b1, 16'($urandom), 2'b01);
    idle(3);
    rst_pulse();
    idle(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
